mix_columns_seq: RTL

Sequencer that performs the full AES MixColumns (or InvMixColumns) on a 128-bit state using a single shared GF(2^8) byte-by-coefficient multiplier. It multiplies one state byte per cycle by a 4-bit coefficient and accumulates the results with XOR into each output byte. It sits between the round controller (start/done handshake) and the round-key add stage. It trades throughput for area: 64 multiply cycles per state.

---
 rtl/mix_columns_seq_pkg.sv | 24 ++
 rtl/mix_columns_seq_gf_mul_nib.sv | 24 ++
 rtl/mix_columns_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared constants for the sequential AES (Inv)MixColumns engine:
// FSM encoding, circulant coefficient rows and GF(2^8) reduction terms.
package aes_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] INV_COEF [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

  // 0x11B pre-shifted so each overflow bit cancels itself when XORed in
  localparam logic [10:0] RED_B8  = 11'h11B;
  localparam logic [10:0] RED_B9  = 11'h236;
  localparam logic [10:0] RED_B10 = 11'h46C;

  // Byte idx sits at [127-8*idx -: 8]; for 4-bit idx that base is {~idx,3'b000}
  function automatic logic [7:0] get_byte(input logic [127:0] v, input logic [3:0] idx);
    return v[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mix_columns_seq_gf_mul_nib.sv
// Combinational GF(2^8) multiply of a byte by a 4-bit coefficient.
// Carry-less product (11 bits) reduced top-down: bit 10, then 9, then 8.
module gf_mul_nib
  import aes_mc_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [10:0] raw;
  logic [9:0]  r10;
  logic [8:0]  r9;

  assign raw = ({3'b000, a_i}        & {11{b_i[0]}})
             ^ ({2'b00, a_i, 1'b0}   & {11{b_i[1]}})
             ^ ({1'b0, a_i, 2'b00}   & {11{b_i[2]}})
             ^ ({a_i, 3'b000}        & {11{b_i[3]}});

  assign r10 = raw[9:0] ^ (RED_B10[9:0] & {10{raw[10]}});
  assign r9  = r10[8:0] ^ (RED_B9[8:0]  & {9{r10[9]}});
  assign p_o = r9[7:0]  ^ (RED_B8[7:0]  & {8{r9[8]}});

endmodule

// File: rtl/mix_columns_seq.sv
// Full-state (Inv)MixColumns using one shared byte x nibble multiplier, one product per cycle.
// 64 multiply cycles then a one-cycle done; start is ignored while busy.
module mix_columns_seq
  import aes_mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inverse,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d, row_q, row_d, k_q, k_d;
  logic [7:0]   acc_q, acc_d;
  logic [127:0] st_q, st_d;
  logic         inv_q, inv_d;
  logic [127:0] res_q, res_d;
  logic [127:0] out_q, out_d;

  logic [1:0]   src_row;
  logic [7:0]   mul_a;
  logic [3:0]   mul_b;
  logic [7:0]   prod;
  logic         last;

  // Operand row rotates with k so out[r] = XOR_k C[k]*s[(r+k) mod 4]
  always_comb begin
    src_row = row_q + k_q;
    mul_a   = get_byte(st_q, {col_q, src_row});
    mul_b   = inv_q ? INV_COEF[k_q][3:0] : FWD_COEF[k_q][3:0];
    last    = (col_q == 2'd3) && (row_q == 2'd3) && (k_q == 2'd3);
  end

  gf_mul_nib u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MUL;
      ST_MUL:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    k_d   = k_q;
    acc_d = acc_q;
    st_d  = st_q;
    inv_d = inv_q;
    res_d = res_q;
    out_d = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          st_d  = data_in;
          inv_d = inverse;
          col_d = 2'd0;
          row_d = 2'd0;
          k_d   = 2'd0;
          acc_d = 8'h00;
        end
      end
      ST_MUL: begin
        k_d = k_q + 2'd1;
        if (k_q != 2'd3) begin
          acc_d = acc_q ^ prod;
        end else begin
          res_d[{~{col_q, row_q}, 3'b000} +: 8] = acc_q ^ prod;
          acc_d = 8'h00;
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) col_d = col_q + 2'd1;
        end
        // Publish the whole state at once so data_out never shows a partial result
        if (last) out_d = res_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= 2'd0;
      row_q <= 2'd0;
      k_q   <= 2'd0;
      acc_q <= 8'h00;
      st_q  <= '0;
      inv_q <= 1'b0;
      res_q <= '0;
      out_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      k_q   <= k_d;
      acc_q <= acc_d;
      st_q  <= st_d;
      inv_q <= inv_d;
      res_q <= res_d;
      out_q <= out_d;
    end
  end

  assign data_out = out_q;

endmodule
